// File: rtl/bus_demux_if.sv
// Bus bundle for bus_demux: narrow word stream in, wide framed word out.
interface bus_demux_if #(
    parameter int unsigned NUM_OUTPUT = 8,
    parameter int unsigned SEL_BIT    = 3,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]            in_data;
    logic                             in_valid;
    logic                             in_last;
    logic                             in_ready;
    logic [NUM_OUTPUT*DATA_WIDTH-1:0] data_out;
    logic [NUM_OUTPUT-1:0]            lane_mask;
    logic                             out_valid;
    logic                             out_ready;
    logic [SEL_BIT-1:0]               sel_out;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, data_out, lane_mask, out_valid, sel_out
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, data_out, lane_mask, out_valid, sel_out
    );
endinterface

// File: rtl/bus_demux.sv
// Deserialising demultiplexer: collects consecutive stream words into lanes
// of a wide frame, double-buffered between a collector and an output register.
module bus_demux #(
    parameter int unsigned NUM_OUTPUT = 8,
    parameter int unsigned SEL_BIT    = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    bus_demux_if.slave  bus
);
    typedef enum logic {FILL, HOLD} state_e;

    state_e                               state_q;
    logic                                 in_ready_q;
    logic                                 out_valid_q;
    logic [NUM_OUTPUT-1:0][DATA_WIDTH-1:0] coll_q, coll_d, dout_q;
    logic [NUM_OUTPUT-1:0]                mask_q, mask_d, lmask_q;
    logic [SEL_BIT-1:0]                   sel_q;

    logic accept_c, out_free_c, last_lane_c, complete_c;

    assign accept_c    = bus.in_valid && in_ready_q;
    assign out_free_c  = !out_valid_q || bus.out_ready;
    assign last_lane_c = (sel_q == SEL_BIT'(NUM_OUTPUT - 1));
    assign complete_c  = accept_c && (last_lane_c || bus.in_last);

    // Collector contents with the incoming word merged into lane sel.
    always_comb begin
        coll_d = coll_q;
        mask_d = mask_q;
        for (int k = 0; k < int'(NUM_OUTPUT); k++) begin
            if (sel_q == SEL_BIT'(k)) begin
                coll_d[k] = bus.in_data;
                mask_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            coll_q      <= '0;
            mask_q      <= '0;
            dout_q      <= '0;
            lmask_q     <= '0;
            sel_q       <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (accept_c) begin
                        if (complete_c) begin
                            sel_q <= '0;
                            if (out_free_c) begin
                                dout_q      <= coll_d;
                                lmask_q     <= mask_d;
                                out_valid_q <= 1'b1;
                                coll_q      <= '0;
                                mask_q      <= '0;
                            end else begin
                                // Output register busy: park the frame in the collector.
                                coll_q     <= coll_d;
                                mask_q     <= mask_d;
                                state_q    <= HOLD;
                                in_ready_q <= 1'b0;
                            end
                        end else begin
                            coll_q <= coll_d;
                            mask_q <= mask_d;
                            sel_q  <= sel_q + SEL_BIT'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        dout_q      <= coll_q;
                        lmask_q     <= mask_q;
                        out_valid_q <= 1'b1;
                        coll_q      <= '0;
                        mask_q      <= '0;
                        state_q     <= FILL;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= FILL;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = dout_q;
    assign bus.lane_mask = lmask_q;
    assign bus.sel_out   = sel_q;
endmodule

// File: tb/tb_bus_demux.sv
// Directed self-checking bench for bus_demux with the default 8x8-bit geometry.
module tb_bus_demux;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    bus_demux_if #(.NUM_OUTPUT(8), .SEL_BIT(3), .DATA_WIDTH(8)) bus ();

    bus_demux #(.NUM_OUTPUT(8), .SEL_BIT(3), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.data_out !== 64'h0) begin n_err++; $display("FAIL reset_data_out got %h want 0", bus.data_out); end
        n_cmp++; if (bus.lane_mask !== 8'h00) begin n_err++; $display("FAIL reset_lane_mask got %h want 00", bus.lane_mask); end
        n_cmp++; if (bus.sel_out !== 3'd0) begin n_err++; $display("FAIL reset_sel_out got %0d want 0", bus.sel_out); end
    endtask

    task automatic test_full_frame();
        logic [7:0] w [8];
        w = '{8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h88};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            bus.in_last  = 1'b0;
            step();
            if (i < 7) begin
                n_cmp++; if (bus.sel_out !== 3'(i + 1)) begin n_err++; $display("FAIL full_sel_step got %0d want %0d", bus.sel_out, i + 1); end
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL full_out_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.data_out !== 64'h88F6E5D4C3B2A100) begin n_err++; $display("FAIL full_data got %h want 88F6E5D4C3B2A100", bus.data_out); end
        n_cmp++; if (bus.lane_mask !== 8'hFF) begin n_err++; $display("FAIL full_mask got %h want FF", bus.lane_mask); end
        n_cmp++; if (bus.sel_out !== 3'd0) begin n_err++; $display("FAIL full_sel_wrap got %0d want 0", bus.sel_out); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL full_valid_pulse got %b want 0", bus.out_valid); end
    endtask

    task automatic test_short_frame();
        logic [7:0] w [3];
        w = '{8'h11, 8'h22, 8'h33};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            bus.in_last  = (i == 2);
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL short_out_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.data_out !== 64'h0000000000332211) begin n_err++; $display("FAIL short_data got %h want 0000000000332211", bus.data_out); end
        n_cmp++; if (bus.lane_mask !== 8'h07) begin n_err++; $display("FAIL short_mask got %h want 07", bus.lane_mask); end
        n_cmp++; if (bus.sel_out !== 3'd0) begin n_err++; $display("FAIL short_sel got %0d want 0", bus.sel_out); end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h44;
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.sel_out !== 3'd1) begin n_err++; $display("FAIL short_next_lane got %0d want 1", bus.sel_out); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL short_valid_clear got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i < 8) ? 8'(i + 1) : 8'(8'h11 + i - 8);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_word%0d got %b want 1", i, bus.in_ready); end
            step();
        end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.data_out !== 64'h0807060504030201) begin n_err++; $display("FAIL bp_frame1 got %h want 0807060504030201", bus.data_out); end
        bus.in_data = 8'h21;
        step();
        n_cmp++; if (bus.sel_out !== 3'd0) begin n_err++; $display("FAIL bp_21_rejected sel got %0d want 0", bus.sel_out); end
        n_cmp++; if (bus.data_out !== 64'h0807060504030201) begin n_err++; $display("FAIL bp_frame1_hold got %h want 0807060504030201", bus.data_out); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.data_out !== 64'h1817161514131211) begin n_err++; $display("FAIL bp_frame2 got %h want 1817161514131211", bus.data_out); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_frame2_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_resume got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.sel_out !== 3'd0) begin n_err++; $display("FAIL bp_21_still_pending sel got %0d want 0", bus.sel_out); end
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.sel_out !== 3'd1) begin n_err++; $display("FAIL bp_21_accepted sel got %0d want 1", bus.sel_out); end
        n_cmp++; if (bus.data_out !== 64'h1817161514131211) begin n_err++; $display("FAIL bp_frame2_hold got %h want 1817161514131211", bus.data_out); end
    endtask

    task automatic test_streaming();
        logic [63:0] exp_frame;
        logic [7:0]  d;
        do_reset();
        bus.out_ready = 1'b1;
        exp_frame = '0;
        for (int c = 0; c < 32; c++) begin
            d = 8'((c / 8) * 16 + (c % 8) + 1);
            exp_frame[(c % 8) * 8 +: 8] = d;
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready cyc%0d got %b want 1", c, bus.in_ready); end
            step();
            n_cmp++; if (bus.out_valid !== ((c % 8) == 7)) begin n_err++; $display("FAIL stream_valid cyc%0d got %b want %b", c, bus.out_valid, (c % 8) == 7); end
            if ((c % 8) == 7) begin
                n_cmp++; if (bus.data_out !== exp_frame) begin n_err++; $display("FAIL stream_frame%0d got %h want %h", c / 8, bus.data_out, exp_frame); end
                exp_frame = '0;
            end
        end
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_idle_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_frame();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h50 + i);
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.sel_out !== 3'd4) begin n_err++; $display("FAIL mid_pre_sel got %0d want 4", bus.sel_out); end
        rst = 1'b1;
        #2;
        n_cmp++; if (bus.sel_out !== 3'd0) begin n_err++; $display("FAIL mid_async_sel got %0d want 0", bus.sel_out); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_async_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.data_out !== 64'h0 || bus.lane_mask !== 8'h00) begin n_err++; $display("FAIL mid_async_out got %h/%h want 0/00", bus.data_out, bus.lane_mask); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'hA0 + i);
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL mid_frame_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.data_out !== 64'hA7A6A5A4A3A2A1A0) begin n_err++; $display("FAIL mid_frame_data got %h want A7A6A5A4A3A2A1A0", bus.data_out); end
        n_cmp++; if (bus.lane_mask !== 8'hFF) begin n_err++; $display("FAIL mid_frame_mask got %h want FF", bus.lane_mask); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_backpressure();
        test_streaming();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_demux.md
# bus_demux

Deserialising demultiplexer: accepts a stream of DATA_WIDTH-bit words on a valid/ready input and distributes consecutive words onto lanes 0..NUM_OUTPUT-1 of a wide output bus. It presents each completed frame as one NUM_OUTPUT*DATA_WIDTH-bit word with its own valid/ready handshake. It is the receiving counterpart of bus_mux, which selects one of several lanes onto a single bus. Typical use: the far end of a link that bus_mux drives as its select steps through all lanes.

## Interface
- NUM_OUTPUT, 8, number of output lanes (2..2^SEL_BIT)
- SEL_BIT, 3, width of lane index; 2^SEL_BIT >= NUM_OUTPUT
- DATA_WIDTH, 8, bits per lane
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  DATA_WIDTH  stream word
- in_valid  input  1  in_data valid
- in_last  input  1  qualifies the word as the final word of a short frame
- in_ready  output  1  block can accept a word
- data_out  output  NUM_OUTPUT*DATA_WIDTH  frame; lane k = bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
- lane_mask  output  NUM_OUTPUT  bit k set = lane k written in this frame
- out_valid  output  1  data_out/lane_mask valid
- out_ready  input  1  consumer takes frame
- sel_out  output  SEL_BIT  lane the next accepted word is written to

## Operation
- Datapath: collector register (NUM_OUTPUT lanes plus mask), output register (data_out, lane_mask, out_valid) and lane counter sel.
- Accept occurs when in_valid and in_ready are both 1. On accept:
  - in_data is written to collector lane sel.
  - Mask bit sel is set.
  - sel increments.
- A frame completes on an accept with sel == NUM_OUTPUT-1, or on an accept with in_last = 1.
- On completion, sel wraps to 0. This holds for non-power-of-two NUM_OUTPUT; sel never reaches NUM_OUTPUT.
- in_last on the word written to lane NUM_OUTPUT-1 is a normal completion.
- Output register is free when out_valid = 0, or when out_valid = 1 and out_ready = 1 in the same cycle.
- State machine, states FILL and HOLD:
  - FILL: in_ready = 1. On completion with output register free, the completed frame (including the word accepted this cycle) loads into the output register. out_valid = 1, the collector and mask clear, and the state stays FILL. On completion with output register not free, go to HOLD; the collector retains the frame.
  - HOLD: in_ready = 0. When out_ready = 1, the collector loads into the output register, out_valid stays 1, the collector clears, and the state returns to FILL.
- Short frame: lanes not written read 0 in data_out; lane_mask shows the written lanes only.
- An out_valid/out_ready handshake with no pending frame clears out_valid to 0.
- data_out and lane_mask hold stable while out_valid = 1 and out_ready = 0.
- in_data, in_last are ignored when in_valid = 0 or in_ready = 0.

## Timing
- Reset values, applied asynchronously:
  - in_ready = 1
  - out_valid = 0
  - data_out = 0
  - lane_mask = 0
  - sel_out = 0
  - state FILL
  - collector = 0
- Handshakes while rst = 1 are ignored.
- in_ready is a function of state only; it has no combinational path from out_ready or in_valid.
- Latency: out_valid rises on the rising edge at which the completing word is accepted, and is visible the following cycle.
- Throughput: one word per cycle with no bubbles while out_ready = 1. A full frame is produced every NUM_OUTPUT cycles.
- With out_ready = 0, the block buffers one frame in the output register and one in the collector, then stalls (in_ready = 0).
- Reset mid-frame: partial collector contents are discarded, and the next accepted word goes to lane 0.
- sel_out updates on the same edge as the accept.

## Test plan
- Reset: assert rst for 3 cycles -> in_ready=1, out_valid=0, data_out=0, lane_mask=0, sel_out=0.
- Full frame: send 00,A1,B2,C3,D4,E5,F6,88 back-to-back with out_ready=1 -> the next cycle shows out_valid=1 for exactly one cycle, data_out=64'h88F6E5D4C3B2A100, lane_mask=8'hFF, sel_out=0.
- Short frame: send 11,22,33 with in_last on 33 -> data_out=64'h0000000000332211, lane_mask=8'h07; the next frame starts at lane 0.
- Backpressure:
  - With out_ready=0, send frames of 01..08 then 11..18 -> after the 16th word in_ready=0 and data_out holds frame 1.
  - Offer word 21 -> it is not accepted.
  - Raise out_ready for 1 cycle -> data_out becomes 64'h1817161514131211 and in_ready=1; 21 is then accepted into lane 0.
- Streaming: send 4 consecutive full frames with out_ready=1 -> in_ready never drops, out_valid pulses every 8 cycles, each frame matches its input.
- Reset mid-frame: after 4 words, pulse rst asynchronously -> outputs return to reset values; a subsequent 8-word frame appears intact with lane_mask=8'hFF.
